// File: rtl/counter_7seg_pkg.sv
// Shared constants and the 7-segment glyph table for the BCD counter display.
package counter_7seg_pkg;

   // All segments off on a common-anode display (active-low segments).
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] BCD_MAX   = 4'd9;

   // Active-low glyphs ordered {CA,CB,CC,CD,CE,CF,CG}; non-BCD codes show nothing.
   function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = 7'b0000001;
         4'd1:    seg = 7'b1001111;
         4'd2:    seg = 7'b0010010;
         4'd3:    seg = 7'b0000110;
         4'd4:    seg = 7'b1001100;
         4'd5:    seg = 7'b0100100;
         4'd6:    seg = 7'b0100000;
         4'd7:    seg = 7'b0001111;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0000100;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_counter_7seg_mux_tick_gen.sv
// Free-running clock divider producing a one-cycle Tick every DIVIDE cycles.
module tick_gen #(
   parameter int DIVIDE = 2
) (
   input  logic Clock,
   input  logic Clear,
   output logic Tick
);

   localparam int CW = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign Tick = (cnt_q == LAST);

   // Count 0..DIVIDE-1, returning to 0 right after the tick cycle.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (Tick) cnt_d = '0;
   end

   // Divider state register; Clear restarts the period.
   always_ff @(posedge Clock) begin
      if (Clear) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/bcd_counter_7seg_mux.sv
// N-digit BCD up/down counter with a multiplexed common-anode 7-segment driver.
module bcd_counter_7seg_mux
   import counter_7seg_pkg::*;
#(
   parameter int DIGITS        = 8,
   parameter int CLOCK_HZ      = 100_000_000,
   parameter int COUNT_HZ      = 1,
   parameter int REFRESH_HZ    = 1000,
   parameter bit WRAP          = 1'b1,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                  Clock,
   input  logic                  Clear,
   input  logic                  Enable,
   input  logic                  Up_down,
   input  logic                  Load,
   input  logic [4*DIGITS-1:0]   Data,
   output logic [4*DIGITS-1:0]   Count,
   output logic                  Terminal,
   output logic [DIGITS-1:0]     AN,
   output logic [6:0]            Segments,
   output logic                  DP
);

   localparam int W  = 4 * DIGITS;
   localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic count_tick, refresh_tick;

   tick_gen #(.DIVIDE(CLOCK_HZ / COUNT_HZ)) u_count_tick (
      .Clock (Clock),
      .Clear (Clear),
      .Tick  (count_tick)
   );

   tick_gen #(.DIVIDE(CLOCK_HZ / REFRESH_HZ)) u_refresh_tick (
      .Clock (Clock),
      .Clear (Clear),
      .Tick  (refresh_tick)
   );

   logic [W-1:0]      count_q, count_d;
   logic              term_q, term_d;
   logic [W-1:0]      inc_val, dec_val, load_val;
   logic [DIGITS:0]   carry, borrow;
   logic [DIGITS-1:0] is_nine, is_zero;

   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;

   // Per-digit BCD increment/decrement chains and load clamping.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic [3:0] cur, ld;
      assign cur        = count_q[4*g +: 4];
      assign ld         = Data[4*g +: 4];
      assign is_nine[g] = (cur == BCD_MAX);
      assign is_zero[g] = (cur == 4'd0);
      assign inc_val[4*g +: 4] = carry[g]  ? (is_nine[g] ? 4'd0 : cur + 4'd1) : cur;
      assign dec_val[4*g +: 4] = borrow[g] ? (is_zero[g] ? BCD_MAX : cur - 4'd1) : cur;
      assign carry[g+1]  = carry[g]  & is_nine[g];
      assign borrow[g+1] = borrow[g] & is_zero[g];
      assign load_val[4*g +: 4] = (ld > BCD_MAX) ? BCD_MAX : ld;
   end

   logic at_limit;
   assign at_limit = Up_down ? (&is_nine) : (&is_zero);

   // Next count: Load beats a counting tick; a limit tick flags Terminal and wraps or holds.
   always_comb begin
      count_d = count_q;
      term_d  = 1'b0;
      if (Load) begin
         count_d = load_val;
      end else if (Enable && count_tick) begin
         term_d = at_limit;
         if (!(at_limit && !WRAP)) count_d = Up_down ? inc_val : dec_val;
      end
   end

   // Counter and terminal-pulse registers.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         count_q <= '0;
         term_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         term_q  <= term_d;
      end
   end

   assign Count    = count_q;
   assign Terminal = term_q;

   logic [SW-1:0]     scan_q, scan_d;
   logic [SW-1:0]     msd;
   logic [3:0]        shown;
   logic              blank;
   logic [DIGITS-1:0] an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;

   // Scan index advance, leading-zero mask and next display drive.
   always_comb begin
      scan_d = scan_q;
      if (refresh_tick) scan_d = (scan_q == SW'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
      msd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!is_zero[i]) msd = SW'(i);
      end
      blank = BLANK_LEADING && (scan_q > msd);
      shown = 4'd0;
      an_d  = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (SW'(i) == scan_q) begin
            shown   = count_q[4*i +: 4];
            an_d[i] = blank;
         end
      end
      seg_d = blank ? SEG_BLANK : seg_decode(shown);
      dp_d  = !((scan_q == '0) && !Enable);
   end

   // Scan position and registered display outputs.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         scan_q <= '0;
         an_q   <= '1;
         seg_q  <= SEG_BLANK;
         dp_q   <= 1'b1;
      end else begin
         scan_q <= scan_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
      end
   end

   assign AN       = an_q;
   assign Segments = seg_q;
   assign DP       = dp_q;

endmodule
